// File: rtl/ct_had_pkg.sv
// Shared HAD definitions: DDC controller state encoding, store size and
// counter widths, plus state-class helpers used by the DDC control logic.
package ct_had_pkg;

  // Bytes advanced in DADDR per completed store.
  localparam int unsigned DDC_STORE_SIZE = 8;
  // Width of the completed-store counter.
  localparam int unsigned DDC_CNT_W      = 16;

  typedef enum logic [3:0] {
    DDC_IDLE   = 4'd0,
    DDC_A_ISS  = 4'd1,
    DDC_A_WT   = 4'd2,
    DDC_D_WAIT = 4'd3,
    DDC_D_ISS  = 4'd4,
    DDC_D_WT   = 4'd5,
    DDC_S_ISS  = 4'd6,
    DDC_S_WT   = 4'd7,
    DDC_ERR    = 4'd8
  } ddc_state_t;

  // Instruction-issue states (one cycle each).
  function automatic logic ddc_is_iss(input ddc_state_t s);
    return (s == DDC_A_ISS) || (s == DDC_D_ISS) || (s == DDC_S_ISS);
  endfunction

  // Waiting-for-retire states.
  function automatic logic ddc_is_wt(input ddc_state_t s);
    return (s == DDC_A_WT) || (s == DDC_D_WT) || (s == DDC_S_WT);
  endfunction

endpackage

// File: rtl/ct_had_ddc_tout.sv
// Wait-state timeout counter for the DDC controller.
// Ports: cpuclk/cpurst_b clock and async active-low reset; i_clr clears the
// count; i_inc advances it; o_expire_c flags that this increment reaches
// all-ones.
module ct_had_ddc_tout #(
  parameter int unsigned TOUT_W = 8
) (
  input  logic cpuclk,
  input  logic cpurst_b,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire_c
);

  // Count value one below all-ones: incrementing from here reaches all-ones.
  localparam logic [TOUT_W-1:0] LAST_M1 = {{(TOUT_W-1){1'b1}}, 1'b0};

  logic [TOUT_W-1:0] r_cnt;

  // Counter register.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + TOUT_W'(1);
    end
  end

  assign o_expire_c = i_inc && (r_cnt == LAST_M1);

endmodule

// File: rtl/ct_had_ddc_ctrl.sv
// DDC (debug direct copy) controller: sequences address load, data load and
// store instructions injected into the core from JTAG DADDR/DDATA writes.
// Ports: cpuclk/cpurst_b clock and async active-low reset; hcr_ddc_en mode
// enable; x_sm_xx_update_dr_en with ir_xx_daddr/ddata_reg_sel form the
// register-write strobes; rtu_had_inst_retire/expt report the injected
// instruction result; ddc_ctrl_dp_* steer the datapath; ddc_xx_update_ir
// launches an instruction; ddc_regs_* report busy, sticky error/overrun and
// completed store count.
module ct_had_ddc_ctrl
  import ct_had_pkg::*;
#(
  parameter int unsigned TOUT_W = 8
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  input  logic                 hcr_ddc_en,
  input  logic                 x_sm_xx_update_dr_en,
  input  logic                 ir_xx_daddr_reg_sel,
  input  logic                 ir_xx_ddata_reg_sel,
  input  logic                 rtu_had_inst_retire,
  input  logic                 rtu_had_inst_expt,
  output logic                 ddc_ctrl_dp_addr_sel,
  output logic                 ddc_ctrl_dp_data_sel,
  output logic                 ddc_ctrl_dp_addr_gen,
  output logic                 ddc_xx_update_ir,
  output logic                 ddc_regs_busy,
  output logic                 ddc_regs_err,
  output logic                 ddc_regs_ovf,
  output logic [DDC_CNT_W-1:0] ddc_regs_cnt
);

  ddc_state_t           r_state;
  ddc_state_t           w_next;
  logic                 w_daddr_wr;
  logic                 w_ddata_wr;
  logic                 w_err_set;
  logic                 w_store_done;
  logic                 w_start;
  logic                 w_ovf_set;
  logic                 w_tout;
  logic                 r_addr_sel;
  logic                 r_data_sel;
  logic                 r_addr_gen;
  logic                 r_update_ir;
  logic                 r_busy;
  logic                 r_err;
  logic                 r_ovf;
  logic [DDC_CNT_W-1:0] r_cnt;

  ct_had_ddc_tout #(.TOUT_W(TOUT_W)) u_tout (
    .cpuclk     (cpuclk),
    .cpurst_b   (cpurst_b),
    .i_clr      (ddc_is_iss(r_state)),
    .i_inc      (ddc_is_wt(r_state)),
    .o_expire_c (w_tout)
  );

  // Next-state decode; disabling DDC mode overrides everything.
  always_comb begin
    w_daddr_wr   = x_sm_xx_update_dr_en & ir_xx_daddr_reg_sel;
    w_ddata_wr   = x_sm_xx_update_dr_en & ir_xx_ddata_reg_sel;
    w_next       = r_state;
    w_err_set    = 1'b0;
    w_store_done = 1'b0;
    if (!hcr_ddc_en) begin
      w_next = DDC_IDLE;
    end else begin
      case (r_state)
        DDC_IDLE:   if (w_daddr_wr) w_next = DDC_A_ISS;
        DDC_A_ISS:  w_next = DDC_A_WT;
        DDC_D_ISS:  w_next = DDC_D_WT;
        DDC_S_ISS:  w_next = DDC_S_WT;
        DDC_A_WT, DDC_D_WT, DDC_S_WT: begin
          // Exception beats retire; retire beats timeout.
          if (rtu_had_inst_expt) begin
            w_next    = DDC_ERR;
            w_err_set = 1'b1;
          end else if (rtu_had_inst_retire) begin
            case (r_state)
              DDC_A_WT: w_next = DDC_D_WAIT;
              DDC_D_WT: w_next = DDC_S_ISS;
              default: begin
                w_next       = DDC_D_WAIT;
                w_store_done = 1'b1;
              end
            endcase
          end else if (w_tout) begin
            w_next    = DDC_ERR;
            w_err_set = 1'b1;
          end
        end
        DDC_D_WAIT: begin
          if (w_daddr_wr)      w_next = DDC_A_ISS;
          else if (w_ddata_wr) w_next = DDC_D_ISS;
        end
        DDC_ERR:    w_next = DDC_ERR;
        default:    w_next = DDC_IDLE;
      endcase
    end
    w_start   = (r_state == DDC_IDLE) && (w_next == DDC_A_ISS);
    w_ovf_set = (ddc_is_iss(r_state) || ddc_is_wt(r_state)) && (w_daddr_wr || w_ddata_wr);
  end

  // State and registered outputs; outputs decoded from next state so they
  // line up with the state they describe.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= DDC_IDLE;
      r_addr_sel  <= 1'b0;
      r_data_sel  <= 1'b0;
      r_addr_gen  <= 1'b0;
      r_update_ir <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next;
      r_update_ir <= ddc_is_iss(w_next);
      r_addr_sel  <= (w_next == DDC_A_ISS) || (w_next == DDC_A_WT);
      r_data_sel  <= (w_next == DDC_D_ISS) || (w_next == DDC_D_WT);
      r_busy      <= !((w_next == DDC_IDLE) || (w_next == DDC_D_WAIT) || (w_next == DDC_ERR));
      r_addr_gen  <= w_store_done;
      if (w_start)        r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (w_start)        r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      if (w_start)           r_cnt <= '0;
      else if (w_store_done) r_cnt <= r_cnt + DDC_CNT_W'(1);
    end
  end

  assign ddc_ctrl_dp_addr_sel = r_addr_sel;
  assign ddc_ctrl_dp_data_sel = r_data_sel;
  assign ddc_ctrl_dp_addr_gen = r_addr_gen;
  assign ddc_xx_update_ir     = r_update_ir;
  assign ddc_regs_busy        = r_busy;
  assign ddc_regs_err         = r_err;
  assign ddc_regs_ovf         = r_ovf;
  assign ddc_regs_cnt         = r_cnt;

endmodule

// File: tb/tb_ct_had_ddc_ctrl.sv
// Directed bench for ct_had_ddc_ctrl (TOUT_W = 4).
// Output vector order: {update_ir, addr_sel, data_sel, addr_gen, busy, err, ovf}.
module tb_ct_had_ddc_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        en = 1'b0;
  logic        upd = 1'b0;
  logic        asel = 1'b0;
  logic        dsel = 1'b0;
  logic        retire = 1'b0;
  logic        expt = 1'b0;
  logic        addr_sel, data_sel, addr_gen, update_ir, busy, err, ovf;
  logic [15:0] cnt;

  int pass_cnt = 0;
  int total    = 0;
  int n_upd    = 0;
  int n_gen    = 0;
  int s_upd, s_gen;
  logic [6:0] o;

  ct_had_ddc_ctrl #(.TOUT_W(4)) dut (
    .cpuclk               (clk),
    .cpurst_b             (rst_b),
    .hcr_ddc_en           (en),
    .x_sm_xx_update_dr_en (upd),
    .ir_xx_daddr_reg_sel  (asel),
    .ir_xx_ddata_reg_sel  (dsel),
    .rtu_had_inst_retire  (retire),
    .rtu_had_inst_expt    (expt),
    .ddc_ctrl_dp_addr_sel (addr_sel),
    .ddc_ctrl_dp_data_sel (data_sel),
    .ddc_ctrl_dp_addr_gen (addr_gen),
    .ddc_xx_update_ir     (update_ir),
    .ddc_regs_busy        (busy),
    .ddc_regs_err         (err),
    .ddc_regs_ovf         (ovf),
    .ddc_regs_cnt         (cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (update_ir) n_upd++;
    if (addr_gen)  n_gen++;
  end

  function automatic logic [6:0] obs();
    return {update_ir, addr_sel, data_sel, addr_gen, busy, err, ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle JTAG Update-DR with the given register selects.
  task automatic wr(input logic a, input logic d);
    upd = 1'b1; asel = a; dsel = d;
    tick();
    upd = 1'b0; asel = 1'b0; dsel = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    o = obs();
    total++; if (o !== 7'b0000000 || cnt !== 16'd0) $display("FAIL reset: out=%b cnt=%0d want 0000000/0", o, cnt); else pass_cnt++;
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    wr(1'b1, 1'b0);  // en low: must stay idle
    o = obs();
    total++; if (o !== 7'b0000000) $display("FAIL idle_en0: out=%b want 0000000", o); else pass_cnt++;
  endtask

  task automatic test_single_store();
    s_upd = n_upd; s_gen = n_gen;
    en = 1'b1;
    wr(1'b1, 1'b0);
    o = obs();
    total++; if (o !== 7'b1100100) $display("FAIL ss_a_iss: out=%b want 1100100", o); else pass_cnt++;
    tick();
    o = obs();
    total++; if (o !== 7'b0100100) $display("FAIL ss_a_wt: out=%b want 0100100", o); else pass_cnt++;
    repeat (2) tick();
    retire = 1'b1; tick(); retire = 1'b0;
    o = obs();
    total++; if (o !== 7'b0000000) $display("FAIL ss_d_wait: out=%b want 0000000", o); else pass_cnt++;
    wr(1'b0, 1'b1);
    o = obs();
    total++; if (o !== 7'b1010100) $display("FAIL ss_d_iss: out=%b want 1010100", o); else pass_cnt++;
    tick();
    retire = 1'b1; tick(); retire = 1'b0;
    o = obs();
    total++; if (o !== 7'b1000100) $display("FAIL ss_s_iss: out=%b want 1000100", o); else pass_cnt++;
    tick();
    retire = 1'b1; tick(); retire = 1'b0;
    o = obs();
    total++; if (o !== 7'b0001000 || cnt !== 16'd1) $display("FAIL ss_done: out=%b cnt=%0d want 0001000/1", o, cnt); else pass_cnt++;
    tick();
    o = obs();
    total++; if (o !== 7'b0000000) $display("FAIL ss_gen_1cyc: out=%b want 0000000", o); else pass_cnt++;
    total++; if (n_upd - s_upd !== 3 || n_gen - s_gen !== 1) $display("FAIL ss_pulses: upd=%0d gen=%0d want 3/1", n_upd - s_upd, n_gen - s_gen); else pass_cnt++;
  endtask

  task automatic test_burst();
    en = 1'b0; tick(); en = 1'b1;
    wr(1'b1, 1'b0);
    total++; if (cnt !== 16'd0) $display("FAIL burst_cnt_clr: cnt=%0d want 0", cnt); else pass_cnt++;
    s_gen = n_gen;
    retire = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 1'b1);
      repeat (4) tick();
    end
    retire = 1'b0;
    o = obs();
    total++; if (o !== 7'b0001000 || cnt !== 16'd4) $display("FAIL burst_end: out=%b cnt=%0d want 0001000/4", o, cnt); else pass_cnt++;
    tick();
    total++; if (n_gen - s_gen !== 4) $display("FAIL burst_gen: got %0d want 4", n_gen - s_gen); else pass_cnt++;
  endtask

  task automatic test_exception();
    wr(1'b0, 1'b1);
    tick();
    s_upd = n_upd;
    expt = 1'b1; retire = 1'b1; tick(); expt = 1'b0; retire = 1'b0;
    o = obs();
    total++; if (o !== 7'b0000010) $display("FAIL expt_err: out=%b want 0000010", o); else pass_cnt++;
    repeat (2) tick();
    total++; if (n_upd - s_upd !== 0 || obs() !== 7'b0000010) $display("FAIL expt_hold: upd=%0d out=%b want 0/0000010", n_upd - s_upd, obs()); else pass_cnt++;
    en = 1'b0; tick();
    o = obs();
    total++; if (o !== 7'b0000010) $display("FAIL expt_idle: out=%b want 0000010", o); else pass_cnt++;
  endtask

  task automatic test_timeout();
    en = 1'b1;
    wr(1'b1, 1'b0);
    o = obs();
    total++; if (o !== 7'b1100100) $display("FAIL to_start_clr: out=%b want 1100100", o); else pass_cnt++;
    tick();
    repeat (14) tick();
    o = obs();
    total++; if (o !== 7'b0100100) $display("FAIL to_still_wt: out=%b want 0100100", o); else pass_cnt++;
    tick();
    o = obs();
    total++; if (o !== 7'b0000010) $display("FAIL to_err: out=%b want 0000010", o); else pass_cnt++;
    en = 1'b0; tick();
  endtask

  task automatic test_overrun();
    en = 1'b1;
    wr(1'b1, 1'b0);
    retire = 1'b1;
    repeat (2) tick();
    wr(1'b0, 1'b1);
    repeat (3) tick();
    o = obs();
    total++; if (o !== 7'b0000100) $display("FAIL ovr_s_wt: out=%b want 0000100", o); else pass_cnt++;
    wr(1'b0, 1'b1);
    o = obs();
    total++; if (o !== 7'b0001001 || cnt !== 16'd1) $display("FAIL ovr_done: out=%b cnt=%0d want 0001001/1", o, cnt); else pass_cnt++;
    retire = 1'b0;
  endtask

  task automatic test_abort();
    wr(1'b0, 1'b1);
    tick();
    o = obs();
    total++; if (o !== 7'b0010101) $display("FAIL ab_d_wt: out=%b want 0010101", o); else pass_cnt++;
    s_upd = n_upd; s_gen = n_gen;
    en = 1'b0; retire = 1'b1; tick();
    o = obs();
    total++; if (o !== 7'b0000001) $display("FAIL ab_idle: out=%b want 0000001", o); else pass_cnt++;
    repeat (2) tick();
    retire = 1'b0;
    total++; if (n_upd - s_upd !== 0 || n_gen - s_gen !== 0) $display("FAIL ab_pulses: upd=%0d gen=%0d want 0/0", n_upd - s_upd, n_gen - s_gen); else pass_cnt++;
  endtask

  task automatic test_priority();
    en = 1'b1;
    wr(1'b1, 1'b0);
    retire = 1'b1;
    repeat (2) tick();
    retire = 1'b0;
    wr(1'b1, 1'b1);
    o = obs();
    total++; if (o !== 7'b1100100) $display("FAIL prio_daddr: out=%b want 1100100", o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    retire = 1'b1;
    repeat (2) tick();
    wr(1'b0, 1'b1);
    repeat (4) tick();
    wr(1'b0, 1'b1);
    repeat (2) tick();
    retire = 1'b0;
    tick();
    o = obs();
    total++; if (o !== 7'b0000100 || cnt !== 16'd1) $display("FAIL rm_s_wt: out=%b cnt=%0d want 0000100/1", o, cnt); else pass_cnt++;
    rst_b = 1'b0;
    #1;
    o = obs();
    total++; if (o !== 7'b0000000 || cnt !== 16'd0) $display("FAIL rm_async: out=%b cnt=%0d want 0000000/0", o, cnt); else pass_cnt++;
    s_upd = n_upd; s_gen = n_gen;
    retire = 1'b1;
    repeat (2) tick();
    rst_b = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    o = obs();
    total++; if (o !== 7'b0000000 || n_upd - s_upd !== 0 || n_gen - s_gen !== 0)
      $display("FAIL rm_after: out=%b upd=%0d gen=%0d want 0000000/0/0", o, n_upd - s_upd, n_gen - s_gen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_burst();
    test_exception();
    test_timeout();
    test_overrun();
    test_abort();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
